// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared types and default timing constants for the snake game
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } sched_state_t;

  localparam int DEF_BASE_FRAMES = 30;
  localparam int DEF_STEP_FRAMES = 2;
  localparam int DEF_MIN_FRAMES  = 4;
  localparam int DEF_MAX_LEVEL   = 13;

endpackage

// File: rtl/frame_divider.sv
// rtl/frame_divider.sv - frame counter with a terminal count reloaded at each wrap
module frame_divider
  import snake_pkg::*;
#(
  parameter int FWIDTH      = 6,
  parameter int BASE_FRAMES = DEF_BASE_FRAMES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [FWIDTH-1:0] reload_period,
  output logic [FWIDTH-1:0] count,
  output logic [FWIDTH-1:0] period_cur,
  output logic              wrap
);

  assign wrap = enable && (count == period_cur - 1'b1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count      <= '0;
      period_cur <= FWIDTH'(BASE_FRAMES);
    end else if (wrap) begin
      count      <= '0;
      period_cur <= reload_period;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// rtl/game_tick_scheduler.sv - paces snake steps from frame pulses with run/pause/over control
module game_tick_scheduler
  import snake_pkg::*;
#(
  parameter int FWIDTH      = 6,
  parameter int LWIDTH      = 4,
  parameter int BASE_FRAMES = DEF_BASE_FRAMES,
  parameter int STEP_FRAMES = DEF_STEP_FRAMES,
  parameter int MIN_FRAMES  = DEF_MIN_FRAMES,
  parameter int MAX_LEVEL   = DEF_MAX_LEVEL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_pulse,
  input  logic              start,
  input  logic              pause_toggle,
  input  logic              level_up,
  input  logic              game_over,
  input  logic              step_ack,
  output logic              step_req,
  output logic              overrun,
  output logic [LWIDTH-1:0] level,
  output sched_state_t      state
);

  localparam int PW = FWIDTH + LWIDTH;

  logic              count_en;
  logic              restart;
  logic              wrap;
  logic [FWIDTH-1:0] count;
  logic [FWIDTH-1:0] period_cur;
  logic [PW-1:0]     dec_w;
  logic [PW-1:0]     period_w;
  logic [FWIDTH-1:0] next_period;

  // game_over and pause_toggle both pre-empt counting of a coincident frame
  assign count_en = (state == RUN) && frame_pulse && !game_over && !pause_toggle;
  assign restart  = start && ((state == IDLE) || (state == OVER));

  // Clamp in wide arithmetic so high levels never wrap below the floor
  always_comb begin
    dec_w = PW'(level) * PW'(STEP_FRAMES);
    if (dec_w + PW'(MIN_FRAMES) >= PW'(BASE_FRAMES)) period_w = PW'(MIN_FRAMES);
    else                                              period_w = PW'(BASE_FRAMES) - dec_w;
    next_period = FWIDTH'(period_w);
  end

  frame_divider #(
    .FWIDTH      (FWIDTH),
    .BASE_FRAMES (BASE_FRAMES)
  ) u_frame_divider (
    .clk           (clk),
    .reset         (reset),
    .enable        (count_en),
    .clear         (restart),
    .reload_period (next_period),
    .count         (count),
    .period_cur    (period_cur),
    .wrap          (wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      level    <= '0;
      step_req <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state   <= RUN;
            level   <= '0;
            overrun <= 1'b0;
          end
        end
        RUN: begin
          if (game_over)         state <= OVER;
          else if (pause_toggle) state <= PAUSED;
          if (level_up && (level < LWIDTH'(MAX_LEVEL))) level <= level + 1'b1;
        end
        PAUSED: begin
          if (game_over)         state <= OVER;
          else if (pause_toggle) state <= RUN;
        end
        default: state <= IDLE;
      endcase

      // A boundary while a request is still unacked is dropped and flagged
      if (state == OVER || (game_over && (state == RUN || state == PAUSED))) begin
        step_req <= 1'b0;
      end else if (wrap) begin
        if (!step_req || step_ack) step_req <= 1'b1;
        else                       overrun  <= 1'b1;
      end else if (step_req && step_ack) begin
        step_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb/tb_game_tick_scheduler.sv - directed scoreboard bench for game_tick_scheduler
module tb_game_tick_scheduler;
  import snake_pkg::*;

  logic         clk = 1'b0;
  logic         reset, frame_pulse, start, pause_toggle, level_up, game_over, step_ack;
  logic         step_req, overrun;
  logic [3:0]   level;
  sched_state_t state;

  int checks = 0;
  int fails  = 0;
  int exp_q[$];
  int n;

  game_tick_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .frame_pulse  (frame_pulse),
    .start        (start),
    .pause_toggle (pause_toggle),
    .level_up     (level_up),
    .game_over    (game_over),
    .step_ack     (step_ack),
    .step_req     (step_req),
    .overrun      (overrun),
    .level        (level),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic frame();
    frame_pulse = 1'b1;
    cyc();
    frame_pulse = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic frames(input int k);
    for (int i = 0; i < k; i++) frame();
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_toggle = 1'b1; cyc(); pause_toggle = 1'b0;
  endtask

  task automatic pulse_level(input int k);
    for (int i = 0; i < k; i++) begin
      level_up = 1'b1; cyc(); level_up = 1'b0;
    end
  endtask

  task automatic ack();
    cyc(); cyc();
    step_ack = 1'b1; cyc(); step_ack = 1'b0;
  endtask

  task automatic run_until_step(input int maxp, output int cnt);
    cnt = 0;
    while (!step_req && cnt < maxp) begin
      frame();
      cnt++;
    end
  endtask

  task automatic expect_step(input string tag, input int frames_exp);
    int got;
    exp_q.push_back(frames_exp);
    run_until_step(frames_exp + 8, got);
    check(tag, got, exp_q.pop_front());
  endtask

  initial begin
    reset = 1'b1; frame_pulse = 0; start = 0; pause_toggle = 0;
    level_up = 0; game_over = 0; step_ack = 0;
    cyc(); cyc();
    check("rst_state", 32'(state), 32'(IDLE));
    check("rst_level", 32'(level), 0);
    check("rst_req", 32'(step_req), 0);
    check("rst_overrun", 32'(overrun), 0);
    reset = 1'b0;
    cyc();

    // Base period and handshake
    pulse_start();
    check("t1_state_run", 32'(state), 32'(RUN));
    expect_step("t1_first_step", 30);
    ack();
    check("t1_req_dropped", 32'(step_req), 0);
    expect_step("t1_second_step", 30);
    ack();
    check("t1_overrun", 32'(overrun), 0);

    // Level change applies only at the next reload
    frames(10);
    pulse_level(3);
    check("t2_level", 32'(level), 3);
    expect_step("t2_current_period", 20);
    ack();
    expect_step("t2_next_period", 24);
    ack();

    // Level saturation and period floor
    pulse_level(20);
    check("t3_level_sat", 32'(level), 13);
    expect_step("t3_period_24", 24);
    ack();
    expect_step("t3_period_floor", 4);
    ack();
    pulse_level(1);
    check("t3_level_hold", 32'(level), 13);

    // Overrun on an unacked boundary
    expect_step("t4_step", 4);
    check("t4_no_overrun_yet", 32'(overrun), 0);
    frames(4);
    check("t4_req_held", 32'(step_req), 1);
    check("t4_overrun_set", 32'(overrun), 1);
    ack();
    check("t4_req_acked", 32'(step_req), 0);
    check("t4_overrun_sticky", 32'(overrun), 1);
    game_over = 1'b1; cyc(); game_over = 1'b0;
    check("t4_over_state", 32'(state), 32'(OVER));
    check("t4_overrun_in_over", 32'(overrun), 1);
    pulse_start();
    check("t4_overrun_cleared", 32'(overrun), 0);

    // Pause freezes the count
    frames(10);
    pulse_pause();
    check("t5_paused", 32'(state), 32'(PAUSED));
    pulse_start();
    check("t5_start_ignored", 32'(state), 32'(PAUSED));
    frames(50);
    check("t5_no_step_paused", 32'(step_req), 0);
    pulse_pause();
    check("t5_resumed", 32'(state), 32'(RUN));
    expect_step("t5_resume_count", 20);
    ack();
    frames(29);
    frame_pulse = 1'b1; pause_toggle = 1'b1; cyc();
    frame_pulse = 1'b0; pause_toggle = 1'b0;
    check("t5_coincide_paused", 32'(state), 32'(PAUSED));
    check("t5_coincide_no_step", 32'(step_req), 0);
    cyc();
    pulse_pause();
    frame();
    check("t5_count_was_29", 32'(step_req), 1);

    // game_over drops a pending request; restart reinitialises
    pulse_level(2);
    check("t6_level_2", 32'(level), 2);
    game_over = 1'b1; cyc(); game_over = 1'b0;
    check("t6_over", 32'(state), 32'(OVER));
    check("t6_req_forced_low", 32'(step_req), 0);
    check("t6_level_held", 32'(level), 2);
    pulse_start();
    check("t6_restart_run", 32'(state), 32'(RUN));
    check("t6_restart_level", 32'(level), 0);
    check("t6_restart_overrun", 32'(overrun), 0);

    // Mid-game reset with a pending request
    expect_step("t6_step_before_reset", 30);
    pulse_level(1);
    reset = 1'b1; cyc();
    check("t6_rst_state", 32'(state), 32'(IDLE));
    check("t6_rst_req", 32'(step_req), 0);
    check("t6_rst_level", 32'(level), 0);
    check("t6_rst_overrun", 32'(overrun), 0);
    reset = 1'b0; cyc();
    pulse_start();
    expect_step("t6_period_after_reset", 30);
    ack();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
